// File: rtl/lhs_bridge_pkg.sv
// Shared defaults and helpers for the LHS processor-side flit bridge.
package lhs_bridge_pkg;

    localparam int unsigned LHS_FLIT_WIDTH       = 608;
    localparam int unsigned FLIT_RD_BIT_DEFAULT  = 0;

    // Bits needed to hold any value in 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Registered-flag FIFO with valid/ready on both sides; no same-cycle bypass.
module flit_fifo #(
    parameter int unsigned WIDTH = 608,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             accept_en_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Extra wrap bit distinguishes full from empty when addresses match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // accept_en_q keeps push_ready low during reset and for the release cycle.
    assign push_ready = accept_en_q & ~full;
    assign pop_valid  = ~empty;
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign pop_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            accept_en_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            accept_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/lhs_flit_bridge.sv
// Buffers PE request/response flits around the LHS decoder port and throttles
// read issue so every outstanding read has a guaranteed response slot.
module lhs_flit_bridge
    import lhs_bridge_pkg::*;
#(
    parameter int unsigned LEN_FLIT_DATA_LHS = LHS_FLIT_WIDTH,
    parameter int unsigned REQ_DEPTH         = 8,
    parameter int unsigned RSP_DEPTH         = 8,
    parameter int unsigned MAX_OUTSTANDING   = 8,
    parameter int unsigned FLIT_RD_BIT       = FLIT_RD_BIT_DEFAULT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      pe_req_valid,
    input  logic [LEN_FLIT_DATA_LHS-1:0]              pe_req_data,
    output logic                                      pe_req_ready,
    output logic                                      pe_rsp_valid,
    output logic [LEN_FLIT_DATA_LHS-1:0]              pe_rsp_data,
    input  logic                                      pe_rsp_ready,
    output logic                                      out_LHS_ready_send,
    output logic [LEN_FLIT_DATA_LHS-1:0]              out_LHS_FLIT_data,
    input  logic                                      in_cd_ready_to_receive,
    input  logic                                      in_fu_ready_to_send,
    input  logic [LEN_FLIT_DATA_LHS-1:0]              in_LHS_FLIT_data,
    output logic                                      out_LHS_ready_receive,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0]     outstanding,
    output logic                                      err_unexpected_rsp
);

    localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic                         req_head_valid;
    logic [LEN_FLIT_DATA_LHS-1:0] req_head_data;
    logic                         req_pop_ready;
    logic                         throttle;
    logic                         issue_fire;
    logic                         issue_rd;
    logic                         rsp_push;
    logic                         has_outstanding;
    logic [CW-1:0]                outstanding_q, outstanding_d;
    logic                         err_q, err_d;

    flit_fifo #(
        .WIDTH (LEN_FLIT_DATA_LHS),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (pe_req_valid),
        .push_data  (pe_req_data),
        .push_ready (pe_req_ready),
        .pop_valid  (req_head_valid),
        .pop_data   (req_head_data),
        .pop_ready  (req_pop_ready)
    );

    flit_fifo #(
        .WIDTH (LEN_FLIT_DATA_LHS),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_fu_ready_to_send),
        .push_data  (in_LHS_FLIT_data),
        .push_ready (out_LHS_ready_receive),
        .pop_valid  (pe_rsp_valid),
        .pop_data   (pe_rsp_data),
        .pop_ready  (pe_rsp_ready)
    );

    // Throttle depends only on registered state, so the decoder's ready never
    // reaches out_LHS_ready_send combinationally.
    assign throttle           = req_head_data[FLIT_RD_BIT] & (outstanding_q == MAX_CNT);
    assign out_LHS_ready_send = req_head_valid & ~throttle;
    assign out_LHS_FLIT_data  = req_head_data;
    assign req_pop_ready      = in_cd_ready_to_receive & ~throttle;

    assign issue_fire      = out_LHS_ready_send & in_cd_ready_to_receive;
    assign issue_rd        = issue_fire & req_head_data[FLIT_RD_BIT];
    assign rsp_push        = in_fu_ready_to_send & out_LHS_ready_receive;
    assign has_outstanding = (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (issue_rd && !(rsp_push && has_outstanding)) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue_rd && rsp_push && has_outstanding) begin
            outstanding_d = outstanding_q - 1'b1;
        end
        // A stray response is still buffered; only the sticky flag records it.
        if (rsp_push && !has_outstanding) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign outstanding        = outstanding_q;
    assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_lhs_flit_bridge.sv
// Scoreboard bench for lhs_flit_bridge: queue-based reference model checked at
// every negedge, with directed scenarios followed by a randomized phase.
module tb_lhs_flit_bridge;
    import lhs_bridge_pkg::*;

    localparam int W     = 608;
    localparam int DEPTH = 8;
    localparam int MAXO  = 8;
    localparam int RD    = 0;
    localparam int CW    = cnt_width(MAXO);

    typedef logic [W-1:0] flit_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pe_req_valid = 1'b0;
    flit_t         pe_req_data = '0;
    logic          pe_req_ready;
    logic          pe_rsp_valid;
    flit_t         pe_rsp_data;
    logic          pe_rsp_ready = 1'b0;
    logic          out_LHS_ready_send;
    flit_t         out_LHS_FLIT_data;
    logic          in_cd_ready_to_receive = 1'b0;
    logic          in_fu_ready_to_send = 1'b0;
    flit_t         in_LHS_FLIT_data = '0;
    logic          out_LHS_ready_receive;
    logic [CW-1:0] outstanding;
    logic          err_unexpected_rsp;

    always #5 clk = ~clk;

    lhs_flit_bridge #(
        .LEN_FLIT_DATA_LHS (W),
        .REQ_DEPTH         (DEPTH),
        .RSP_DEPTH         (DEPTH),
        .MAX_OUTSTANDING   (MAXO),
        .FLIT_RD_BIT       (RD)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .pe_req_valid           (pe_req_valid),
        .pe_req_data            (pe_req_data),
        .pe_req_ready           (pe_req_ready),
        .pe_rsp_valid           (pe_rsp_valid),
        .pe_rsp_data            (pe_rsp_data),
        .pe_rsp_ready           (pe_rsp_ready),
        .out_LHS_ready_send     (out_LHS_ready_send),
        .out_LHS_FLIT_data      (out_LHS_FLIT_data),
        .in_cd_ready_to_receive (in_cd_ready_to_receive),
        .in_fu_ready_to_send    (in_fu_ready_to_send),
        .in_LHS_FLIT_data       (in_LHS_FLIT_data),
        .out_LHS_ready_receive  (out_LHS_ready_receive),
        .outstanding            (outstanding),
        .err_unexpected_rsp     (err_unexpected_rsp)
    );

    // Reference model: request flits awaiting issue, responses awaiting the PE,
    // reads owed a response, and the sticky error.
    flit_t exp_issue[$];
    flit_t exp_rsp[$];
    int    m_out = 0;
    bit    m_err = 1'b0;
    bit    live = 1'b0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    req_acc = 1'b0;
    bit    rsp_acc = 1'b0;
    int    issue_log[$];
    int    req_log[$];
    int    rsp_log[$];
    flit_t last_popped = '0;

    function automatic void chk(input string name, input flit_t act, input flit_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic flit_t rand_flit(input bit rd);
        flit_t f;
        for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
        f[RD] = rd;
        return f;
    endfunction

    always @(posedge clk) begin
        live <= rst;
        cyc  <= cyc + 1;
    end

    bit exp_send, throttled, rd_issue;

    // Monitor: compare against the model, then fold in the handshakes that the
    // coming edge will complete.
    always @(negedge clk) begin
        if (!rst) begin
            exp_issue.delete();
            exp_rsp.delete();
            m_out   = 0;
            m_err   = 1'b0;
            req_acc = 1'b0;
            rsp_acc = 1'b0;
            chk("rst_req_ready", pe_req_ready, 0);
            chk("rst_rsp_valid", pe_rsp_valid, 0);
            chk("rst_send", out_LHS_ready_send, 0);
            chk("rst_receive", out_LHS_ready_receive, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_err", err_unexpected_rsp, 0);
            chk("rst_issue_data", out_LHS_FLIT_data, 0);
            chk("rst_rsp_data", pe_rsp_data, 0);
        end else begin
            throttled = exp_issue.size() > 0 && exp_issue[0][RD] && m_out == MAXO;
            exp_send  = exp_issue.size() > 0 && !throttled;
            chk("issue_valid", out_LHS_ready_send, exp_send);
            chk("req_ready", pe_req_ready, live && exp_issue.size() < DEPTH);
            chk("rsp_valid", pe_rsp_valid, exp_rsp.size() > 0);
            chk("rsp_receive", out_LHS_ready_receive, live && exp_rsp.size() < DEPTH);
            chk("outstanding", outstanding, m_out);
            chk("err_flag", err_unexpected_rsp, m_err);
            if (exp_rsp.size() > 0) chk("rsp_data", pe_rsp_data, exp_rsp[0]);
            if (exp_send) chk("issue_data", out_LHS_FLIT_data, exp_issue[0]);

            rd_issue = 1'b0;
            if (out_LHS_ready_send && in_cd_ready_to_receive && exp_issue.size() > 0) begin
                rd_issue = exp_issue[0][RD];
                void'(exp_issue.pop_front());
                issue_log.push_back(cyc);
            end
            if (pe_rsp_valid && pe_rsp_ready && exp_rsp.size() > 0) begin
                last_popped = exp_rsp.pop_front();
            end
            req_acc = pe_req_valid && pe_req_ready;
            if (req_acc) begin
                exp_issue.push_back(pe_req_data);
                req_log.push_back(cyc);
            end
            rsp_acc = in_fu_ready_to_send && out_LHS_ready_receive;
            if (rsp_acc) begin
                exp_rsp.push_back(in_LHS_FLIT_data);
                rsp_log.push_back(cyc);
                if (m_out == 0) m_err = 1'b1;
            end
            m_out = m_out + int'(rd_issue) - int'(rsp_acc && m_out > 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic push_reqs(input int n, input bit rd);
        int got = 0;
        int guard = 0;
        pe_req_valid = 1'b1;
        pe_req_data  = rand_flit(rd);
        while (got < n && guard < 500) begin
            tick();
            guard++;
            if (req_acc) begin
                got++;
                pe_req_data = rand_flit(rd);
            end
        end
        pe_req_valid = 1'b0;
        if (got < n) chk("push_timeout", got, n);
    endtask

    task automatic send_rsps(input int n);
        int got = 0;
        int guard = 0;
        in_fu_ready_to_send = 1'b1;
        in_LHS_FLIT_data    = rand_flit($urandom_range(0, 1));
        while (got < n && guard < 500) begin
            tick();
            guard++;
            if (rsp_acc) begin
                got++;
                in_LHS_FLIT_data = rand_flit($urandom_range(0, 1));
            end
        end
        in_fu_ready_to_send = 1'b0;
        if (got < n) chk("rsp_timeout", got, n);
    endtask

    initial begin
        flit_t d9;
        int    guard;

        // Power-on reset
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(2);

        // Throughput: 8 back-to-back writes
        in_cd_ready_to_receive = 1'b1;
        pe_rsp_ready = 1'b1;
        issue_log.delete();
        req_log.delete();
        push_reqs(8, 1'b0);
        wait_cycles(4);
        chk("tput_count", issue_log.size(), 8);
        if (issue_log.size() == 8 && req_log.size() == 8) begin
            chk("tput_first_latency", issue_log[0], req_log[0] + 1);
            for (int i = 1; i < 8; i++) chk("tput_consecutive", issue_log[i], issue_log[0] + i);
        end
        chk("tput_outstanding", outstanding, 0);

        // Throttle: 9 reads, the 9th waits for one response
        issue_log.delete();
        push_reqs(9, 1'b1);
        wait_cycles(5);
        @(negedge clk);
        chk("throttle_held", out_LHS_ready_send, 0);
        chk("throttle_out8", outstanding, 8);
        chk("throttle_issued8", issue_log.size(), 8);
        tick();
        issue_log.delete();
        rsp_log.delete();
        send_rsps(1);
        wait_cycles(3);
        chk("unthrottle_count", issue_log.size(), 1);
        if (issue_log.size() == 1 && rsp_log.size() == 1)
            chk("unthrottle_next_cycle", issue_log[0], rsp_log[0] + 1);
        @(negedge clk);
        chk("unthrottle_out8", outstanding, 8);
        tick();
        send_rsps(8);
        wait_cycles(3);
        chk("drained_out0", outstanding, 0);

        // Simultaneous read issue and response at outstanding=4
        in_cd_ready_to_receive = 1'b0;
        push_reqs(4, 1'b1);
        in_cd_ready_to_receive = 1'b1;
        wait_cycles(4);
        in_cd_ready_to_receive = 1'b0;
        push_reqs(1, 1'b1);
        wait_cycles(2);
        issue_log.delete();
        rsp_log.delete();
        in_cd_ready_to_receive = 1'b1;
        in_fu_ready_to_send    = 1'b1;
        in_LHS_FLIT_data       = rand_flit(1'b0);
        tick();
        in_cd_ready_to_receive = 1'b0;
        in_fu_ready_to_send    = 1'b0;
        @(negedge clk);
        chk("simul_out4", outstanding, 4);
        chk("simul_events", issue_log.size() + rsp_log.size(), 2);
        if (issue_log.size() == 1 && rsp_log.size() == 1)
            chk("simul_same_cycle", issue_log[0], rsp_log[0]);
        tick();
        in_cd_ready_to_receive = 1'b1;
        send_rsps(4);
        wait_cycles(3);

        // Backpressure: 8 responses fill the FIFO, the 9th (unexpected) waits
        push_reqs(8, 1'b1);
        wait_cycles(4);
        chk("bp_out8", outstanding, 8);
        pe_rsp_ready = 1'b0;
        send_rsps(8);
        d9 = rand_flit(1'b1);
        in_fu_ready_to_send = 1'b1;
        in_LHS_FLIT_data    = d9;
        wait_cycles(3);
        @(negedge clk);
        chk("bp_receive_low", out_LHS_ready_receive, 0);
        chk("bp_rsp_valid", pe_rsp_valid, 1);
        chk("bp_err_clear", err_unexpected_rsp, 0);
        tick();
        pe_rsp_ready = 1'b1;
        tick();
        pe_rsp_ready = 1'b0;
        guard = 0;
        while (!rsp_acc && guard < 20) begin
            tick();
            guard++;
        end
        chk("bp_9th_accepted", rsp_acc, 1);
        in_fu_ready_to_send = 1'b0;
        pe_rsp_ready = 1'b1;
        wait_cycles(12);
        chk("bp_9th_intact", last_popped, d9);
        chk("err_set", err_unexpected_rsp, 1);
        wait_cycles(5);
        chk("err_sticky", err_unexpected_rsp, 1);

        // Asynchronous reset with 3 flits queued
        in_cd_ready_to_receive = 1'b0;
        push_reqs(3, 1'b0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_req_ready", pe_req_ready, 0);
        chk("arst_send", out_LHS_ready_send, 0);
        chk("arst_receive", out_LHS_ready_receive, 0);
        chk("arst_rsp_valid", pe_rsp_valid, 0);
        chk("arst_outstanding", outstanding, 0);
        chk("arst_err", err_unexpected_rsp, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        issue_log.delete();
        in_cd_ready_to_receive = 1'b1;
        wait_cycles(5);
        chk("arst_no_stale_issue", issue_log.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (!pe_req_valid || req_acc) begin
                pe_req_valid = ($urandom_range(0, 3) != 0);
                pe_req_data  = rand_flit($urandom_range(0, 1));
            end
            in_cd_ready_to_receive = ($urandom_range(0, 3) != 0);
            pe_rsp_ready = ($urandom_range(0, 2) != 0);
            if (!in_fu_ready_to_send || rsp_acc) begin
                in_fu_ready_to_send = (m_out > 0) && ($urandom_range(0, 2) != 0);
                in_LHS_FLIT_data    = rand_flit($urandom_range(0, 1));
            end
        end
        tick();
        pe_req_valid = 1'b0;
        in_cd_ready_to_receive = 1'b1;
        pe_rsp_ready = 1'b1;
        guard = 0;
        while ((m_out > 0 || exp_issue.size() > 0) && guard < 300) begin
            if (!in_fu_ready_to_send || rsp_acc) begin
                in_fu_ready_to_send = (m_out > 0);
                in_LHS_FLIT_data    = rand_flit($urandom_range(0, 1));
            end
            tick();
            guard++;
        end
        in_fu_ready_to_send = 1'b0;
        wait_cycles(12);
        chk("final_req_empty", exp_issue.size(), 0);
        chk("final_rsp_empty", exp_rsp.size(), 0);
        chk("final_outstanding", outstanding, 0);
        chk("final_err", err_unexpected_rsp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lhs_flit_bridge.md
# lhs_flit_bridge

Processor-side bridge directly upstream of the memory-subsystem top. It buffers request flits from one LHS processing element and issues them into the command decoder's LHS port. It also buffers the returning response flits from the forwarding unit. An outstanding-read counter throttles issue so response buffering can never overflow.

## Interface
Parameters:
- LEN_FLIT_DATA_LHS, 608: flit width, both directions.
- REQ_DEPTH, 8: request FIFO depth (power of 2, ≥2).
- RSP_DEPTH, 8: response FIFO depth (power of 2, ≥2).
- MAX_OUTSTANDING, 8: read-request cap; must be ≤ RSP_DEPTH.
- FLIT_RD_BIT, 0: flit bit index; 1 = read request (expects exactly one response flit).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- pe_req_valid  in  1  PE offers a request flit.
- pe_req_data  in  LEN_FLIT_DATA_LHS  request flit.
- pe_req_ready  out  1  request FIFO not full.
- pe_rsp_valid  out  1  response FIFO not empty.
- pe_rsp_data  out  LEN_FLIT_DATA_LHS  head response flit.
- pe_rsp_ready  in  1  PE consumes the head response.
- out_LHS_ready_send  out  1  valid to the decoder's LHS port.
- out_LHS_FLIT_data  out  LEN_FLIT_DATA_LHS  flit to the decoder.
- in_cd_ready_to_receive  in  1  decoder ready.
- in_fu_ready_to_send  in  1  response valid from the forwarding unit.
- in_LHS_FLIT_data  in  LEN_FLIT_DATA_LHS  response flit.
- out_LHS_ready_receive  out  1  bridge can accept a response.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads issued but not yet returned.
- err_unexpected_rsp  out  1  sticky; set when a response arrives with outstanding==0.

## Operation
- PE request enqueues when pe_req_valid & pe_req_ready.
- Issue handshake fires when out_LHS_ready_send & in_cd_ready_to_receive.
- Issue gating: out_LHS_ready_send = req FIFO not empty & !(head[FLIT_RD_BIT] & outstanding==MAX_OUTSTANDING). A write at the head is never throttled.
- Data stability: out_LHS_FLIT_data stays stable while out_LHS_ready_send is high and the handshake has not fired.
- Response accept:
  - out_LHS_ready_receive = rsp FIFO not full.
  - A response enqueues on in_fu_ready_to_send & out_LHS_ready_receive.
  - pe_rsp_valid/pe_rsp_data present the FIFO head; pop on pe_rsp_valid & pe_rsp_ready.
- Counter update per cycle:
  - +1 on issue of a read.
  - −1 on response enqueue with outstanding>0.
  - Both events in the same cycle: no change.
  - Response with outstanding==0: flit is still enqueued, counter stays 0, err_unexpected_rsp sets. It clears only on reset.
- FIFO behaviour:
  - Simultaneous push and pop when full: allowed only on the pop side. ready is computed from the registered full flag, so a push is refused when full even if a pop happens that cycle.
  - Simultaneous push and pop when empty: the push lands and the FIFO is not empty next cycle. There is no same-cycle bypass.
  - Pointers carry one extra wrap bit; full = addresses equal and wrap bits differ.
- Reset, asserted asynchronously at any time:
  - Empties both FIFOs.
  - outstanding=0, err_unexpected_rsp=0.
  - All valid/ready outputs low: pe_req_ready=0, pe_rsp_valid=0, out_LHS_ready_send=0, out_LHS_ready_receive=0.
  - Data outputs are 0.
  - Flits in flight are discarded.
  - Ready outputs reassert on the first clk edge after rst deasserts.

## Timing
- Enqueue to out_LHS_ready_send: 1 cycle.
- Response enqueue to pe_rsp_valid: 1 cycle.
- Sustained throughput: one flit per cycle each direction when not throttled or full.
- Counter change is visible the cycle after the handshake. The throttle check uses the registered count, so a response on cycle N unblocks a read issue on cycle N+1.
- All outputs are registered or derived from registered FIFO flags and the head entry. There are no combinational paths from in_cd_ready_to_receive to out_LHS_ready_send.

## Structure
- Package lhs_bridge_pkg holds:
  - the default flit width;
  - the FLIT_RD_BIT default;
  - a clog2-based counter width function.
- Sub-module flit_fifo, parameterised on width and depth, with a valid/ready interface on both sides. It is instantiated twice (request and response).
- The top holds only issue gating, the outstanding counter and the error flag.

## Test plan
- Reset state: rst low mid-stream with 3 flits queued. All valid/ready outputs go 0 immediately, outstanding=0; after release, no stale flit is issued.
- Throughput: push 8 writes back-to-back with in_cd_ready_to_receive=1. They issue on 8 consecutive cycles, first one cycle after the first push, in order; outstanding stays 0.
- Throttle: MAX_OUTSTANDING=8; issue 9 reads with no responses.
  - The 9th read is held with out_LHS_ready_send=0.
  - One response on cycle N lets the 9th issue on N+1; outstanding returns to 8.
- Simultaneous events: a read issue and a response in the same cycle at outstanding=4 leave outstanding at 4.
- Backpressure: pe_rsp_ready=0 while 8 responses arrive. out_LHS_ready_receive drops after the 8th; the 9th is held by the source and is delivered intact after one PE pop.
- Error: a response with outstanding=0 sets err_unexpected_rsp, the flit still reaches pe_rsp_data, and the flag persists until reset.
